// File: rtl/store_write_buffer_pkg.sv
// Shared constants for the store write buffer and its forwarding matcher.
// Widths line up with the core's existing reorder-buffer and function-unit sizing.
package store_write_buffer_pkg;

  localparam int FUNCTION_UNIT_NUMBER    = 4;
  localparam int REORDER_BUFFER_SIZE_LOG = 4;
  localparam int ROB_LOG                 = REORDER_BUFFER_SIZE_LOG;
  localparam int XLEN                    = 32;
  localparam int SWB_DEPTH               = 4;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/store_fwd_match.sv
// Age-prioritized address comparator: scans entries oldest-to-youngest from head
// so the youngest valid entry whose address equals ld_addr wins.
module store_fwd_match
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0] head,
  input  logic [DEPTH-1:0] valid,
  input  word_t            addrs [DEPTH],
  input  word_t            ld_addr,
  output logic             hit,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] slot;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (valid[slot] && addrs[slot] == ld_addr) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Post-execution store buffer: holds completed stores until ROB commit, drains
// committed stores in order to memory, forwards to loads, and drops stores on flush.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH   = SWB_DEPTH,
  parameter int ROB_LOG = store_write_buffer_pkg::ROB_LOG,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [ROB_LOG-1:0] in_position,
  input  word_t              in_addr,
  input  word_t              in_data,
  output logic               in_ready,
  input  logic               commit_valid,
  input  logic [ROB_LOG-1:0] commit_position,
  input  logic               flush,
  output logic               mem_req,
  output word_t              mem_addr,
  output word_t              mem_wdata,
  input  logic               mem_ack,
  input  word_t              ld_addr,
  output logic               fwd_hit,
  output word_t              fwd_data,
  output logic [CNT_W-1:0]   count,
  output logic               error
);

  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   committed_q;
  logic [ROB_LOG-1:0] pos_q  [DEPTH];
  word_t              addr_q [DEPTH];
  word_t              data_q [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;

  logic               accept;
  logic               pop;
  logic               commit_new;
  logic               commit_miss;
  logic [DEPTH-1:0]   commit_hit;
  logic [CNT_W-1:0]   n_committed;
  logic [PTR_W-1:0]   fwd_idx;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign accept    = in_valid && in_ready && !flush;
  assign mem_req   = valid_q[head_q] && committed_q[head_q];
  assign pop       = mem_req && mem_ack;
  assign mem_addr  = mem_req ? addr_q[head_q] : '0;
  assign mem_wdata = mem_req ? data_q[head_q] : '0;

  // A commit may name the store being accepted on the same edge.
  assign commit_new  = commit_valid && accept && (in_position == commit_position);
  assign commit_miss = commit_valid && !(|commit_hit) && !commit_new;

  // Committed entries are the oldest and contiguous from head, so their count
  // tells a flush where the tail must retract to.
  always_comb begin
    commit_hit  = '0;
    n_committed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      commit_hit[i] = commit_valid && valid_q[i] && (pos_q[i] == commit_position);
      n_committed   = n_committed + CNT_W'(valid_q[i] && (committed_q[i] || commit_hit[i]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments; later statements in the
  // block take priority, which orders accept/commit, then flush, then pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      committed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count       <= '0;
      error       <= 1'b0;
    end else begin
      if (accept) begin
        valid_q[tail_q]     <= 1'b1;
        committed_q[tail_q] <= commit_new;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_hit[i]) committed_q[i] <= 1'b1;
        if (flush && !(committed_q[i] || commit_hit[i])) valid_q[i] <= 1'b0;
      end
      if (pop) begin
        valid_q[head_q]     <= 1'b0;
        committed_q[head_q] <= 1'b0;
      end
      head_q <= head_q + PTR_W'(pop);
      if (flush) begin
        tail_q <= head_q + PTR_W'(n_committed);
        count  <= n_committed - CNT_W'(pop);
      end else begin
        tail_q <= tail_q + PTR_W'(accept);
        count  <= count + CNT_W'(accept) - CNT_W'(pop);
      end
      if ((in_valid && !in_ready) || commit_miss) error <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (accept) begin
      pos_q[tail_q]  <= in_position;
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  store_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_match (
    .head    (head_q),
    .valid   (valid_q),
    .addrs   (addr_q),
    .ld_addr (ld_addr),
    .hit     (fwd_hit),
    .idx     (fwd_idx)
  );

  assign fwd_data = fwd_hit ? data_q[fwd_idx] : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer: drain, overflow, flush,
// forwarding, commit corner cases and asynchronous reset mid-transfer.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_position;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_ready;
  logic        commit_valid;
  logic [3:0]  commit_position;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;
  logic        error;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(4), .ROB_LOG(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_position     (in_position),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .commit_valid    (commit_valid),
    .commit_position (commit_position),
    .flush           (flush),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .ld_addr         (ld_addr),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data),
    .count           (count),
    .error           (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] pos, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_position = pos; in_addr = a; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_position = '0; in_addr = '0; in_data = '0;
    commit_valid = 1'b0; commit_position = '0; flush = 1'b0;
    mem_ack = 1'b0; ld_addr = 32'h100;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_error", error, 0);
    reset = 1'b0;

    // Single store: accept, commit, drain with ack held high.
    push(4'd3, 32'h100, 32'hAA);
    check("t1_count_after_accept", count, 1);
    check("t1_fwd_hit", fwd_hit, 1);
    check("t1_fwd_data", fwd_data, 32'hAA);
    check("t1_req_before_commit", mem_req, 0);
    mem_ack = 1'b1;
    commit_valid = 1'b1; commit_position = 4'd3;
    tick();
    commit_valid = 1'b0;
    check("t1_req_after_commit", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_wdata", mem_wdata, 32'hAA);
    check("t1_count_before_pop", count, 1);
    tick();
    check("t1_req_after_pop", mem_req, 0);
    check("t1_count_after_pop", count, 0);
    mem_ack = 1'b0;

    // Overflow: fill four entries (wrapping the pointers), then offer a fifth.
    for (int i = 0; i < 4; i++) push(4'(i), 32'h300 + 32'(4 * i), 32'(i + 1));
    check("t2_count_full", count, 4);
    check("t2_in_ready_full", in_ready, 0);
    check("t2_error_before", error, 0);
    push(4'd9, 32'h3F0, 32'h99);
    check("t2_count_after_drop", count, 4);
    check("t2_error_set", error, 1);
    ld_addr = 32'h3F0;
    #1 check("t2_dropped_not_fwd", fwd_hit, 0);
    ld_addr = 32'h30C;
    #1 check("t2_fwd_youngest_kept", fwd_data, 32'h4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t2_count_after_flush", count, 0);
    reset_pulse();
    check("t2_error_cleared", error, 0);

    // Commit and flush on the same edge: the committed store survives.
    push(4'd1, 32'h400, 32'h1);
    push(4'd2, 32'h404, 32'h2);
    push(4'd3, 32'h408, 32'h3);
    commit_valid = 1'b1; commit_position = 4'd1; flush = 1'b1;
    tick();
    commit_valid = 1'b0; flush = 1'b0;
    check("t3_count_after_flush", count, 1);
    check("t3_mem_req", mem_req, 1);
    check("t3_mem_addr", mem_addr, 32'h400);
    check("t3_mem_wdata", mem_wdata, 32'h1);
    ld_addr = 32'h404;
    #1 check("t3_flushed_not_fwd", fwd_hit, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t3_count_drained", count, 0);
    check("t3_req_drained", mem_req, 0);
    check("t3_error_clean", error, 0);

    // Forwarding: youngest of two stores to the same address wins.
    push(4'd4, 32'h200, 32'h11);
    push(4'd5, 32'h200, 32'h22);
    ld_addr = 32'h200;
    #1;
    check("t4_fwd_hit", fwd_hit, 1);
    check("t4_fwd_data", fwd_data, 32'h22);
    ld_addr = 32'h204;
    #1;
    check("t4_miss_hit", fwd_hit, 0);
    check("t4_miss_data", fwd_data, 0);
    check("t4_count", count, 2);

    // Commit of an unknown position: error only.
    commit_valid = 1'b1; commit_position = 4'd7;
    tick();
    commit_valid = 1'b0;
    check("t5_error_unknown", error, 1);
    check("t5_count_unchanged", count, 2);
    check("t5_req_unchanged", mem_req, 0);
    ld_addr = 32'h200;
    #1 check("t5_fwd_unchanged", fwd_data, 32'h22);
    reset_pulse();
    check("t5_reset_count", count, 0);
    check("t5_reset_error", error, 0);

    // Commit naming the store accepted on the same edge.
    commit_valid = 1'b1; commit_position = 4'd6;
    push(4'd6, 32'h600, 32'h66);
    commit_valid = 1'b0;
    check("t5_same_edge_count", count, 1);
    check("t5_same_edge_req", mem_req, 1);
    check("t5_same_edge_addr", mem_addr, 32'h600);
    check("t5_same_edge_error", error, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t5_same_edge_drained", count, 0);

    // Back-to-back drain of two committed stores with ack held high.
    push(4'd1, 32'h700, 32'h70);
    push(4'd2, 32'h704, 32'h71);
    mem_ack = 1'b1;
    commit_valid = 1'b1; commit_position = 4'd1;
    tick();
    commit_position = 4'd2;
    check("t6_first_addr", mem_addr, 32'h700);
    tick();
    commit_valid = 1'b0;
    check("t6_second_req", mem_req, 1);
    check("t6_second_addr", mem_addr, 32'h704);
    check("t6_second_data", mem_wdata, 32'h71);
    check("t6_count_mid", count, 1);
    tick();
    mem_ack = 1'b0;
    check("t6_count_done", count, 0);
    check("t6_req_done", mem_req, 0);

    // Ack withheld: request held stable, then abandoned by asynchronous reset.
    commit_valid = 1'b1; commit_position = 4'd8;
    push(4'd8, 32'h800, 32'h88);
    commit_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t7_wait_req", mem_req, 1);
      check("t7_wait_addr", mem_addr, 32'h800);
      check("t7_wait_data", mem_wdata, 32'h88);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    check("t7_async_req", mem_req, 0);
    check("t7_async_count", count, 0);
    check("t7_async_addr", mem_addr, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t7_after_reset_req", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
